// File: rtl/load_buffer_pkg.sv
// Shared constants and types for the load path: widths, opcodes, size codes, queue entry.
package load_buffer_pkg;

    localparam int unsigned LBCount       = 8;
    localparam int unsigned LBWidth       = 3;
    localparam int unsigned ROBWidth      = 4;
    localparam int unsigned IDWidth       = 32;
    localparam int unsigned AddressWidth  = 32;
    localparam int unsigned InstTypeWidth = 6;

    // Width of the occupancy counter; needs one extra bit to represent a full queue.
    localparam int unsigned CountWidth = LBWidth + 1;

    typedef logic [InstTypeWidth-1:0] opcode_t;

    // Load opcodes are contiguous so range checks stay cheap.
    localparam opcode_t OpLB  = 6'd10;
    localparam opcode_t OpLH  = 6'd11;
    localparam opcode_t OpLW  = 6'd12;
    localparam opcode_t OpLBU = 6'd13;
    localparam opcode_t OpLHU = 6'd14;

    // Memory access size codes, shared with the store path.
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDrain
    } lb_state_e;

    typedef struct packed {
        logic [AddressWidth-1:0] addr;
        logic [ROBWidth-1:0]     dest;
        opcode_t                 opcode;
    } lb_entry_t;

    function automatic logic is_load_op(opcode_t op);
        return (op >= OpLB) && (op <= OpLHU);
    endfunction

endpackage

// File: rtl/load_buffer_if.sv
// Memory read channel between the load buffer (master) and the memory controller (slave).
interface load_buffer_if;
    import load_buffer_pkg::*;

    logic                    mem_req;
    logic [AddressWidth-1:0] mem_addr;
    logic [1:0]              mem_size;
    logic                    mem_done;
    logic [IDWidth-1:0]      mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_size,
        input  mem_done,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_size,
        output mem_done,
        output mem_data
    );

endinterface

// File: rtl/load_extend.sv
// Opcode-driven size encoding and sign/zero extension of right-aligned load data.
module load_extend
    import load_buffer_pkg::*;
(
    input  opcode_t            opcode_in,
    input  logic [IDWidth-1:0] data_in,
    output logic [IDWidth-1:0] result_out,
    output logic [1:0]         size_out,
    output logic               valid_out
);

    // Decode the opcode into an access size and the extended result.
    always_comb begin
        result_out = '0;
        size_out   = SizeWord;
        valid_out  = 1'b1;
        unique case (opcode_in)
            OpLB: begin
                result_out = {{(IDWidth-8){data_in[7]}}, data_in[7:0]};
                size_out   = SizeByte;
            end
            OpLH: begin
                result_out = {{(IDWidth-16){data_in[15]}}, data_in[15:0]};
                size_out   = SizeHalf;
            end
            OpLW: begin
                result_out = data_in;
                size_out   = SizeWord;
            end
            OpLBU: begin
                result_out = {{(IDWidth-8){1'b0}}, data_in[7:0]};
                size_out   = SizeByte;
            end
            OpLHU: begin
                result_out = {{(IDWidth-16){1'b0}}, data_in[15:0]};
                size_out   = SizeHalf;
            end
            default: begin
                valid_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// In-order load queue: accepts resolved loads, issues one memory read at a time,
// extends the returned data and broadcasts it on the CDB load channel.
module load_buffer
    import load_buffer_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    output logic                    lbuffer_rs_rdy_out,
    input  logic                    addrunit_lbuffer_en_in,
    input  logic [AddressWidth-1:0] addrunit_lbuffer_addr_in,
    input  logic [ROBWidth-1:0]     addrunit_lbuffer_dest_in,
    input  opcode_t                 addrunit_lbuffer_opcode_in,
    input  logic                    rob_lbuffer_rst_in,
    load_buffer_if.master           mem,
    output logic [ROBWidth-1:0]     cdb_lbuffer_b_out,
    output logic [IDWidth-1:0]      cdb_lbuffer_result_out
);

    lb_entry_t               queue_q [LBCount];
    logic [LBWidth-1:0]      head_q, head_d;
    logic [LBWidth-1:0]      tail_q, tail_d;
    logic [CountWidth-1:0]   count_q, count_d;
    lb_state_e               state_q, state_d;
    logic                    req_q, req_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic [ROBWidth-1:0]     cdb_b_q, cdb_b_d;
    logic [IDWidth-1:0]      cdb_result_q, cdb_result_d;

    logic                    push;
    logic                    pop;
    logic                    flush;
    lb_entry_t               head_entry;
    logic [IDWidth-1:0]      ext_result;
    logic [1:0]              ext_size;
    logic                    ext_valid;
    logic [CountWidth-1:0]   free_slots;

    assign flush      = rob_lbuffer_rst_in;
    assign head_entry = queue_q[head_q];

    // The head entry drives both the issue size and the completion extension.
    load_extend u_load_extend (
        .opcode_in  (head_entry.opcode),
        .data_in    (mem.mem_data),
        .result_out (ext_result),
        .size_out   (ext_size),
        .valid_out  (ext_valid)
    );

    // Two free slots cover the load already in flight through the address unit.
    assign free_slots         = CountWidth'(LBCount) - count_q;
    assign lbuffer_rs_rdy_out = free_slots >= CountWidth'(2);

    assign mem.mem_req             = req_q;
    assign mem.mem_addr            = addr_q;
    assign mem.mem_size            = size_q;
    assign cdb_lbuffer_b_out       = cdb_b_q;
    assign cdb_lbuffer_result_out  = cdb_result_q;

    // Next-state logic for the issue FSM, queue pointers and broadcast.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        size_d       = size_q;
        cdb_b_d      = '0;
        cdb_result_d = cdb_result_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    // Issue only from entries present at the start of the cycle.
                    if (!flush && (count_q != '0)) begin
                        req_d   = 1'b1;
                        addr_d  = head_entry.addr;
                        size_d  = ext_size;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (mem.mem_done) begin
                        req_d   = 1'b0;
                        state_d = StIdle;
                        if (!flush) begin
                            cdb_b_d      = head_entry.dest;
                            cdb_result_d = ext_result;
                            pop          = 1'b1;
                        end
                    end else if (flush) begin
                        // The read is already out; wait for it and throw the data away.
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (mem.mem_done) begin
                        req_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            push = addrunit_lbuffer_en_in && !flush && (count_q < CountWidth'(LBCount));

            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                head_d  = head_q + LBWidth'(pop);
                tail_d  = tail_q + LBWidth'(push);
                count_d = count_q + CountWidth'(push) - CountWidth'(pop);
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            cdb_b_q      <= '0;
            cdb_result_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            cdb_b_q      <= cdb_b_d;
            cdb_result_q <= cdb_result_d;
        end
    end

    // Queue storage; entries need no reset since count gates every read.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            queue_q[tail_q] <= '{addr:   addrunit_lbuffer_addr_in,
                                 dest:   addrunit_lbuffer_dest_in,
                                 opcode: addrunit_lbuffer_opcode_in};
        end
    end

    // Simulation checks for protocol violations and non-load opcodes.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            assert (!(addrunit_lbuffer_en_in && !flush && (count_q == CountWidth'(LBCount))))
                else $error("load_buffer: enqueue while full, entry dropped");
            if (state_q == StBusy && mem.mem_done && !flush) begin
                assert (ext_valid && is_load_op(head_entry.opcode))
                    else $error("load_buffer: completing entry with non-load opcode");
            end
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with a transaction-level queue model checked every cycle.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b1;
    logic                    rdy_in = 1'b1;
    logic                    rs_rdy;
    logic                    en = 1'b0;
    logic [AddressWidth-1:0] en_addr = '0;
    logic [ROBWidth-1:0]     en_dest = '0;
    opcode_t                 en_op = OpLW;
    logic                    flush = 1'b0;
    logic [ROBWidth-1:0]     cdb_b;
    logic [IDWidth-1:0]      cdb_res;

    load_buffer_if bus ();

    load_buffer dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        .lbuffer_rs_rdy_out         (rs_rdy),
        .addrunit_lbuffer_en_in     (en),
        .addrunit_lbuffer_addr_in   (en_addr),
        .addrunit_lbuffer_dest_in   (en_dest),
        .addrunit_lbuffer_opcode_in (en_op),
        .rob_lbuffer_rst_in         (flush),
        .mem                        (bus),
        .cdb_lbuffer_b_out          (cdb_b),
        .cdb_lbuffer_result_out     (cdb_res)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  dest;
        logic [5:0]  op;
    } ent_t;

    ent_t        mq[$];        // loads accepted and not yet completed, oldest first
    bit          m_req  = 1'b0;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_size = '0;
    bit          m_live = 1'b0; // outstanding read belongs to mq[0]
    logic [3:0]  m_b    = '0;
    logic [31:0] m_res  = '0;

    logic [3:0]  got_b[$];
    logic [31:0] got_res[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          check_en = 1'b0;

    function automatic logic [31:0] model_ext(logic [31:0] d, logic [5:0] op);
        case (op)
            OpLB:    return 32'($signed(d[7:0]));
            OpLH:    return 32'($signed(d[15:0]));
            OpLBU:   return 32'(d[7:0]);
            OpLHU:   return 32'(d[15:0]);
            OpLW:    return d;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_size(logic [5:0] op);
        if (op == OpLB || op == OpLBU) return 2'b00;
        if (op == OpLH || op == OpLHU) return 2'b01;
        return 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Apply one clock edge of the rules to the model, using the inputs the DUT just sampled.
    task automatic model_step();
        int n_before;
        if (rst_in) begin
            mq.delete();
            m_req = 0; m_addr = '0; m_size = '0; m_live = 0; m_b = '0; m_res = '0;
            return;
        end
        m_b = '0;
        if (!rdy_in) return;
        n_before = int'(mq.size());
        if (m_req) begin
            if (bus.mem_done) begin
                m_req = 0;
                if (m_live && !flush) begin
                    m_b   = mq[0].dest;
                    m_res = model_ext(bus.mem_data, mq[0].op);
                    void'(mq.pop_front());
                end
                m_live = 0;
            end else if (flush) begin
                m_live = 0;
            end
        end else if (n_before > 0 && !flush) begin
            m_req  = 1;
            m_addr = mq[0].addr;
            m_size = model_size(mq[0].op);
            m_live = 1;
        end
        if (flush) mq.delete();
        else if (en && n_before < int'(LBCount)) mq.push_back('{addr: en_addr, dest: en_dest, op: en_op});
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        if (check_en) begin
            chk("mem_req", 32'(bus.mem_req), 32'(m_req));
            if (m_req) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_size", 32'(bus.mem_size), 32'(m_size));
            end
            chk("cdb_b", 32'(cdb_b), 32'(m_b));
            if (m_b != 0) chk("cdb_result", cdb_res, m_res);
            chk("rs_rdy", 32'(rs_rdy), 32'((int'(LBCount) - int'(mq.size())) >= 2));
            if (cdb_b != 0) begin
                got_b.push_back(cdb_b);
                got_res.push_back(cdb_res);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        #1;
        en            = 1'b0;
        flush         = 1'b0;
        rdy_in        = 1'b1;
        bus.mem_done  = 1'b0;
    endtask

    task automatic set_enq(input logic [31:0] a, input logic [3:0] d, input logic [5:0] op);
        en = 1'b1; en_addr = a; en_dest = d; en_op = op;
    endtask

    task automatic enq(input logic [31:0] a, input logic [3:0] d, input logic [5:0] op);
        set_enq(a, d, op);
        tick();
    endtask

    // Wait (bounded) for a request, then answer it after 'delay' cycles.
    task automatic serve(input logic [31:0] data, input int delay);
        int waited = 0;
        while (bus.mem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("serve_req_seen", 32'(bus.mem_req), 32'd1);
        if (bus.mem_req !== 1'b1) return;
        repeat (delay - 1) tick();
        bus.mem_data = data;
        bus.mem_done = 1'b1;
        tick();
    endtask

    task automatic chk_got(input string name, input int idx, input logic [3:0] tag,
                           input logic [31:0] res);
        if (idx < int'(got_b.size())) begin
            chk({name, "_tag"}, 32'(got_b[idx]), 32'(tag));
            chk({name, "_res"}, got_res[idx], res);
        end else begin
            chk({name, "_missing"}, 32'(got_b.size()), 32'(idx + 1));
        end
    endtask

    task automatic clear_got();
        got_b.delete();
        got_res.delete();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = '0;

        // Reset
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        chk("reset_req", 32'(bus.mem_req), 32'd0);
        chk("reset_addr", bus.mem_addr, 32'd0);
        chk("reset_size", 32'(bus.mem_size), 32'd0);
        chk("reset_cdb_b", 32'(cdb_b), 32'd0);
        chk("reset_cdb_res", cdb_res, 32'd0);
        chk("reset_rs_rdy", 32'(rs_rdy), 32'd1);
        check_en = 1'b1;

        // Single LB, memory answers two cycles after the request appears
        clear_got();
        enq(32'h100, 4'd3, OpLB);
        tick();
        chk("t1_req", 32'(bus.mem_req), 32'd1);
        chk("t1_addr", bus.mem_addr, 32'h100);
        chk("t1_size", 32'(bus.mem_size), 32'd0);
        tick();
        bus.mem_data = 32'h0000_00F0;
        bus.mem_done = 1'b1;
        tick();
        chk("t1_b", 32'(cdb_b), 32'd3);
        chk("t1_res", cdb_res, 32'hFFFF_FFF0);
        tick();
        chk("t1_b_one_cycle", 32'(cdb_b), 32'd0);
        chk("t1_count", 32'(got_b.size()), 32'd1);

        // Extension variants, broadcast in enqueue order
        clear_got();
        enq(32'h200, 4'd4, OpLBU);
        enq(32'h204, 4'd5, OpLH);
        enq(32'h208, 4'd6, OpLHU);
        enq(32'h20C, 4'd7, OpLW);
        for (int i = 0; i < 4; i++) serve(32'h1234_8080, 1);
        tick();
        tick();
        chk("t2_count", 32'(got_b.size()), 32'd4);
        chk_got("t2_lbu", 0, 4'd4, 32'h0000_0080);
        chk_got("t2_lh", 1, 4'd5, 32'hFFFF_8080);
        chk_got("t2_lhu", 2, 4'd6, 32'h0000_8080);
        chk_got("t2_lw", 3, 4'd7, 32'h1234_8080);

        // Fill to 7 entries, pointers wrap past index 7
        clear_got();
        for (int i = 1; i <= 7; i++) begin
            enq(32'h1000 + 32'(i * 4), 4'(i), OpLW);
            if (i == 6) chk("t3_rdy_at6", 32'(rs_rdy), 32'd1);
            if (i == 7) chk("t3_rdy_at7", 32'(rs_rdy), 32'd0);
        end
        serve(32'h1111_1111, 1);
        chk("t3_rdy_back", 32'(rs_rdy), 32'd1);
        for (int i = 2; i <= 7; i++) serve(32'h1111_1111 * 32'(i), 2);
        tick();
        chk("t3_count", 32'(got_b.size()), 32'd7);
        for (int i = 1; i <= 7; i++) chk_got("t3_order", i - 1, 4'(i), 32'h1111_1111 * 32'(i));

        // Flush while BUSY; new load enqueued during DRAIN waits for the drained read
        clear_got();
        enq(32'h200, 4'd2, OpLW);
        tick();
        flush = 1'b1;
        tick();
        enq(32'h300, 4'd9, OpLW);
        tick();
        chk("t4_drain_addr", bus.mem_addr, 32'h200);
        bus.mem_data = 32'h0000_DEAD;
        bus.mem_done = 1'b1;
        tick();
        chk("t4_no_bcast", 32'(cdb_b), 32'd0);
        chk("t4_req_drop", 32'(bus.mem_req), 32'd0);
        tick();
        chk("t4_reissue", 32'(bus.mem_req), 32'd1);
        chk("t4_reissue_addr", bus.mem_addr, 32'h300);
        serve(32'h0000_0055, 1);
        tick();
        chk("t4_count", 32'(got_b.size()), 32'd1);
        chk_got("t4_new", 0, 4'd9, 32'h0000_0055);

        // Flush, enqueue and done all in one cycle
        clear_got();
        enq(32'h400, 4'd5, OpLW);
        tick();
        set_enq(32'h404, 4'd6, OpLW);
        bus.mem_data = 32'h0000_BEEF;
        bus.mem_done = 1'b1;
        flush = 1'b1;
        tick();
        chk("t5_req", 32'(bus.mem_req), 32'd0);
        repeat (3) tick();
        chk("t5_idle_req", 32'(bus.mem_req), 32'd0);
        chk("t5_rdy", 32'(rs_rdy), 32'd1);
        chk("t5_count", 32'(got_b.size()), 32'd0);

        // rdy_in low for 4 cycles mid-BUSY; an enqueue during that window is ignored
        clear_got();
        enq(32'h502, 4'd8, OpLH);
        tick();
        for (int i = 0; i < 4; i++) begin
            rdy_in = 1'b0;
            if (i == 1) set_enq(32'h600, 4'd10, OpLW);
            tick();
        end
        chk("t6_req_held", 32'(bus.mem_req), 32'd1);
        chk("t6_addr_held", bus.mem_addr, 32'h502);
        chk("t6_size_held", 32'(bus.mem_size), 32'd1);
        bus.mem_data = 32'h0000_9001;
        bus.mem_done = 1'b1;
        tick();
        repeat (3) tick();
        chk("t6_count", 32'(got_b.size()), 32'd1);
        chk_got("t6_lh", 0, 4'd8, 32'hFFFF_9001);
        chk("t6_idle", 32'(bus.mem_req), 32'd0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- Consumer end of the reservation station's load path.
- Accepts address-resolved load entries from the address unit into an in-order circular queue, then issues one memory read at a time.
- Sign- or zero-extends the returned data and broadcasts it on the CDB load channel (cdb_lbuffer_b / cdb_lbuffer_result).
- Drives the load-buffer-ready flag that gates load issue in the reservation station.

Parameters:
- LBCount, 8, queue depth (power of two).
- LBWidth, 3, log2(LBCount).
- ROBWidth, 4, ROB tag width; tag 0 means "none".
- IDWidth, 32, data width.
- AddressWidth, 32, address width.
- InstTypeWidth, 6, opcode width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; state frozen when low
- lbuffer_rs_rdy_out  out  1  high when at least 2 queue slots are free
- addrunit_lbuffer_en_in  in  1  enqueue strobe
- addrunit_lbuffer_addr_in  in  AddressWidth  effective address
- addrunit_lbuffer_dest_in  in  ROBWidth  destination ROB tag (nonzero)
- addrunit_lbuffer_opcode_in  in  InstTypeWidth  one of LB, LH, LW, LBU, LHU
- rob_lbuffer_rst_in  in  1  misprediction flush
- lbuffer_mem_req_out  out  1  read request, held until done
- lbuffer_mem_addr_out  out  AddressWidth  read address
- lbuffer_mem_size_out  out  2  size code: 00 byte, 01 half, 10 word
- mem_lbuffer_done_in  in  1  one-cycle pulse, data valid
- mem_lbuffer_data_in  in  IDWidth  raw data, right-aligned
- cdb_lbuffer_b_out  out  ROBWidth  broadcast tag; 0 means idle
- cdb_lbuffer_result_out  out  IDWidth  broadcast value

Behaviour:
- Clock is clk_in; reset rst_in is synchronous and active-high. All registers update on posedge clk_in.
- Reset values: head=tail=0, count=0, state=IDLE, lbuffer_mem_req_out=0, addr=0, size=0, cdb_lbuffer_b_out=0, cdb_lbuffer_result_out=0. lbuffer_rs_rdy_out is therefore 1 after reset.
- cdb_lbuffer_b_out defaults to 0 every cycle, including cycles with rdy_in low. It is nonzero for exactly one cycle per completed load.
- rdy_in=0: no other state change.
- lbuffer_rs_rdy_out = (LBCount - count) >= 2. It is combinational from count. The 2-slot slack covers the one-cycle registered RS→address unit→buffer pipeline.
- Enqueue: when en_in=1, write {addr, dest, opcode} at tail; tail=(tail+1) mod LBCount; count+1. Enqueue while count==LBCount is a protocol violation; assert in simulation and drop the entry.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE: if count>0 (queue contents as of the start of the cycle), drive req=1 with addr/size from the head entry; go to BUSY. An entry enqueued this cycle is issued no earlier than the next cycle.
- BUSY: hold req, addr and size stable. On done_in:
  - req=0;
  - cdb_lbuffer_b_out=head.dest next cycle;
  - result=extend(data, head.opcode);
  - pop head (head+1 mod LBCount, count-1);
  - go to IDLE.
  - Net latency from enqueue into an empty buffer: request visible 1 cycle later; broadcast 1 cycle after done.
- Extension rules:
  - LB: sign-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LBU / LHU: zero-extend.
  - LW: pass through.
  - Any other opcode: result 0 plus a simulation assertion.
- Simultaneous enqueue and pop: both take effect; count is unchanged. Wrap-around of head and tail is modulo LBCount.
- Flush (rob_lbuffer_rst_in=1 while rdy_in=1):
  - head=tail=count=0; enqueue in the same cycle is ignored; no broadcast that cycle.
  - If state==BUSY and done_in is not present this cycle: keep req asserted and go to DRAIN.
  - If done_in arrives in the same cycle: discard the data, req=0, go to IDLE.
- DRAIN: hold req until done_in; discard data, no broadcast; req=0; go to IDLE. Enqueues are accepted during DRAIN. lbuffer_rs_rdy_out follows count normally.
- Flush in IDLE: clears the queue only.
- rst_in overrides everything, including an in-flight request. The memory controller is reset by the same rst_in.

Decomposition:
- Shared package (constant.vh):
  - opcode codes LB..LHU, with LB≤op≤LHU contiguous;
  - IDWidth, ROBWidth, AddressWidth, InstTypeWidth;
  - LBCount, LBWidth;
  - size-code constants SizeByte, SizeHalf, SizeWord.
- One combinational sub-module, load_extend (opcode, raw data → extended result, size code), shared with the future store path for size encoding.

Test Plan:
- Reset then single LB at addr 0x100, dest 3; memory returns 0x000000F0 after 2 cycles → req seen 1 cycle after enqueue with size 00 and addr 0x100; cdb_lbuffer_b_out=3 and result=0xFFFFFFF0 for exactly one cycle.
- LBU / LH / LHU / LW with data 0x1234_8080 → results 0x00000080, 0xFFFF8080, 0x00008080, 0x12348080 respectively, broadcast in enqueue order.
- Enqueue 7 loads back-to-back into LBCount=8 → lbuffer_rs_rdy_out drops when count reaches 7 and rises when count returns to 6; head and tail wrap past index 7 without losing entries.
- Flush while BUSY (done arrives 3 cycles later with 0xDEAD) → no broadcast; queue empty; a new LW enqueued during DRAIN issues only after the drained done.
- Flush in the same cycle as enqueue and done → entry dropped, data discarded, cdb_lbuffer_b_out stays 0, state IDLE.
- rdy_in held low 4 cycles mid-BUSY → req, head, count and state all unchanged; cdb_lbuffer_b_out stays 0; operation resumes correctly when rdy_in returns high.
